// File: rtl/slt_serial_pkg.sv
// slt_serial_pkg: FSM state and running decision encodings for the bit-serial signed comparator
package slt_serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {UNDECIDED, LT, GT} dec_t;
endpackage

// File: rtl/slt_serial.sv
// slt_serial: MSB-first bit-serial signed a<b / a==b; start,bit_valid,a_bit,b_bit in; busy,done,out,eq registered out
module slt_serial
  import slt_serial_pkg::*;
#(
  parameter int N = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic out,
  output logic eq
);
  localparam int CW = $clog2(N + 1);
  state_t state, state_n;
  dec_t dec, dec_n;
  logic [CW-1:0] cnt, cnt_n;
  logic out_n, eq_n, lt_bit;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  assign lt_bit = cnt == '0 ? a_bit & ~b_bit : ~a_bit & b_bit;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dec_n = dec;
    out_n = out;
    eq_n = eq;
    case (state)
      IDLE: if (start) begin
        state_n = SHIFT;
        cnt_n = '0;
        dec_n = UNDECIDED;
        out_n = 1'b0;
        eq_n = 1'b0;
      end
      SHIFT: if (cnt == CW'(N)) begin
        state_n = DONE;
        out_n = dec == LT;
        eq_n = dec == UNDECIDED;
      end else if (bit_valid) begin
        cnt_n = cnt + 1'b1;
        if (dec == UNDECIDED && a_bit != b_bit) dec_n = lt_bit ? LT : GT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dec <= UNDECIDED;
      out <= 1'b0;
      eq <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dec <= dec_n;
      out <= out_n;
      eq <= eq_n;
    end
  end
endmodule

// File: tb/tb_slt_serial.sv
// tb_slt_serial: table-driven scoreboard bench for slt_serial
module tb_slt_serial;
  localparam int N = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
  logic busy, done, out, eq;
  int cyc = 0, n_cmp = 0, n_err = 0;
  typedef struct {logic o; logic e; int dc;} exp_t;
  typedef struct {logic [N-1:0] a; logic [N-1:0] b; int gap; int restart; logic o; logic e;} vec_t;
  exp_t sb[$];
  exp_t mx;
  vec_t tbl[9];
  slt_serial #(.N(N)) dut (.clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done), .out(out), .eq(eq));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst && done) begin
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL extra_done at cycle %0d: got done=1 expected done=0", cyc);
    end else begin
      mx = sb.pop_front();
      chk("out", {31'b0, out}, {31'b0, mx.o});
      chk("eq", {31'b0, eq}, {31'b0, mx.e});
      chk("done_cycle", cyc, mx.dc);
    end
  end
  task automatic run(input vec_t v);
    int k = 0;
    int t0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 t0 = cyc;
    start = 1'b0;
    chk("busy_start", {31'b0, busy}, 1);
    for (int i = 0; i < N; i++) begin
      int g = v.gap == 1 ? int'(i > 0) : v.gap == 2 ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        bit_valid = 1'b0;
        @(posedge clk); #1 k++;
      end
      bit_valid = 1'b1;
      a_bit = v.a[N-1-i];
      b_bit = v.b[N-1-i];
      start = i == v.restart;
      @(posedge clk); #1 k++;
      start = 1'b0;
    end
    bit_valid = 1'b0;
    sb.push_back('{v.o, v.e, t0 + k + 1});
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done, expected done at cycle %0d", t0 + k + 1);
      sb.delete();
    end
    @(negedge clk);
    chk("busy_idle", {31'b0, busy}, 0);
    chk("done_idle", {31'b0, done}, 0);
  endtask
  initial begin
    vec_t v;
    logic [N-1:0] m42, m3, m2;
    m42 = -42;
    m3 = -3;
    m2 = -2;
    tbl[0] = '{32'd5, 32'd7, 0, -1, 1'b1, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'd0, 0, -1, 1'b1, 1'b0};
    tbl[2] = '{32'd0, 32'hFFFFFFFF, 0, -1, 1'b0, 1'b0};
    tbl[3] = '{32'h7FFFFFFF, 32'h80000000, 0, -1, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h7FFFFFFF, 0, -1, 1'b1, 1'b0};
    tbl[5] = '{m42, m42, 1, -1, 1'b0, 1'b1};
    tbl[6] = '{32'h80000000, 32'h80000001, 2, -1, 1'b1, 1'b0};
    tbl[7] = '{32'd0, 32'd0, 0, -1, 1'b0, 1'b1};
    tbl[8] = '{m3, m2, 0, 10, 1'b1, 1'b0};
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_out", {31'b0, out}, 0);
    chk("rst_eq", {31'b0, eq}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 9; i++) run(tbl[i]);
    repeat (3) @(negedge clk);
    chk("out_hold", {31'b0, out}, 1);
    for (int j = 0; j < 6; j++) begin
      v.a = $urandom;
      v.b = j % 2 == 1 ? v.a : $urandom;
      v.gap = 2;
      v.restart = -1;
      v.o = $signed(v.a) < $signed(v.b);
      v.e = v.a == v.b;
      run(v);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    bit_valid = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bit_valid = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_out", {31'b0, out}, 0);
    chk("midrst_eq", {31'b0, eq}, 0);
    #2 rst = 1'b0;
    v = '{32'd3, 32'd3, 0, -1, 1'b0, 1'b1};
    run(v);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
